// File: rtl/pim_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pim_ctrl_pkg : shared state encoding and default widths for pim_seq_ctrl    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package pim_ctrl_pkg;

  localparam int PIM_ADDR_W = 10;
  localparam int PIM_LEN_W  = 8;
  localparam int PIM_OP_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_ISSUE  = 3'd2,
    S_UPDATE = 3'd3,
    S_DONE   = 3'd4
  } pim_seq_state_t;

endpackage : pim_ctrl_pkg
`default_nettype wire

// File: rtl/pim_seq_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pim_seq_ctrl_if : instruction, address-register and array-port bundle      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
interface pim_seq_ctrl_if
  import pim_ctrl_pkg::*;
#(
  parameter int N     = PIM_ADDR_W,
  parameter int LEN_W = PIM_LEN_W,
  parameter int OP_W  = PIM_OP_W
) ();

  logic             instr_valid;
  logic             instr_ready;
  logic             instr_mov;
  logic [OP_W-1:0]  instr_op;
  logic [N-1:0]     instr_src_a;
  logic [N-1:0]     instr_src_b;
  logic [N-1:0]     instr_dst;
  logic [LEN_W-1:0] instr_len;
  logic             abort;

  logic [N-1:0]     src_a_d;
  logic [N-1:0]     src_b_d;
  logic [N-1:0]     dst_d;
  logic [N-1:0]     mov_d;
  logic             pim_load;
  logic             mov_load;
  logic             update_load;

  logic             arr_req;
  logic [OP_W-1:0]  arr_op;
  logic             arr_ack;

  logic             busy;
  logic             done;
  logic             aborted;
  logic [LEN_W-1:0] step_cnt;

  // Decoder / datapath side
  modport master (
    output instr_valid, instr_mov, instr_op, instr_src_a, instr_src_b,
           instr_dst, instr_len, abort, arr_ack,
    input  instr_ready, src_a_d, src_b_d, dst_d, mov_d, pim_load, mov_load,
           update_load, arr_req, arr_op, busy, done, aborted, step_cnt
  );

  // Sequencer side
  modport slave (
    input  instr_valid, instr_mov, instr_op, instr_src_a, instr_src_b,
           instr_dst, instr_len, abort, arr_ack,
    output instr_ready, src_a_d, src_b_d, dst_d, mov_d, pim_load, mov_load,
           update_load, arr_req, arr_op, busy, done, aborted, step_cnt
  );

endinterface : pim_seq_ctrl_if
`default_nettype wire

// File: rtl/pim_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pim_seq_ctrl : loads PIM base addresses, steps len array ops, or does MOV  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module pim_seq_ctrl
  import pim_ctrl_pkg::*;
#(
  parameter int N     = PIM_ADDR_W,
  parameter int LEN_W = PIM_LEN_W,
  parameter int OP_W  = PIM_OP_W
) (
  input  logic          clk,
  input  logic          rst_n,
  pim_seq_ctrl_if.slave seq
);

  pim_seq_state_t   r_state;
  pim_seq_state_t   w_next;

  logic             r_mov;
  logic [OP_W-1:0]  r_op;
  logic [N-1:0]     r_src_a;
  logic [N-1:0]     r_src_b;
  logic [N-1:0]     r_dst;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_step;
  logic             r_aborted;

  logic             w_accept;
  logic             w_abort;
  logic             w_step_ack;
  logic             w_last_step;
  logic [LEN_W-1:0] w_step_inc;

  assign w_accept    = (r_state == S_IDLE) && seq.instr_valid;
  assign w_abort     = (r_state != S_IDLE) && seq.abort;
  // Abort wins over a coincident ack, so the count never moves on an abort cycle
  assign w_step_ack  = (r_state == S_ISSUE) && seq.arr_ack && !w_abort
                       && (r_step != r_len);
  assign w_step_inc  = r_step + {{(LEN_W-1){1'b0}}, 1'b1};
  assign w_last_step = (w_step_inc == r_len);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (seq.instr_valid) w_next = S_LOAD;
      S_LOAD:   w_next = (r_mov || (r_len == '0)) ? S_DONE : S_ISSUE;
      S_ISSUE:  if (seq.arr_ack) w_next = w_last_step ? S_DONE : S_UPDATE;
      S_UPDATE: w_next = S_ISSUE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mov   <= 1'b0;
      r_op    <= '0;
      r_src_a <= '0;
      r_src_b <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_step  <= '0;
    end else if (w_accept) begin
      r_mov   <= seq.instr_mov;
      r_op    <= seq.instr_op;
      r_src_a <= seq.instr_src_a;
      r_src_b <= seq.instr_src_b;
      r_dst   <= seq.instr_dst;
      r_len   <= seq.instr_len;
      r_step  <= '0;
    end else if (w_step_ack) begin
      r_step  <= w_step_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aborted <= 1'b0;
    end else begin
      r_aborted <= w_abort;
    end
  end

  // Every control output is a pure state decode, so async reset drops them at once
  assign seq.instr_ready = (r_state == S_IDLE);
  assign seq.busy        = (r_state != S_IDLE);
  assign seq.pim_load    = (r_state == S_LOAD) && !r_mov;
  assign seq.mov_load    = (r_state == S_LOAD) && r_mov;
  assign seq.update_load = (r_state == S_UPDATE);
  assign seq.arr_req     = (r_state == S_ISSUE);
  assign seq.done        = (r_state == S_DONE);
  assign seq.aborted     = r_aborted;

  assign seq.arr_op      = r_op;
  assign seq.src_a_d     = r_src_a;
  assign seq.src_b_d     = r_src_b;
  assign seq.dst_d       = r_dst;
  assign seq.mov_d       = r_src_a;
  assign seq.step_cnt    = r_step;

endmodule : pim_seq_ctrl
`default_nettype wire

// File: tb/tb_pim_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_pim_seq_ctrl : timeline-model checker for pim_seq_ctrl                   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_pim_seq_ctrl;

  localparam int N    = 10;
  localparam int LW   = 8;
  localparam int OW   = 4;
  localparam int TMAX = 600;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pim_seq_ctrl_if #(.N(N), .LEN_W(LW), .OP_W(OW)) bus ();

  pim_seq_ctrl #(.N(N), .LEN_W(LW), .OP_W(OW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Expected outputs for the cycle currently in progress
  bit x_ready, x_busy, x_pl, x_ml, x_ul, x_req, x_done, x_abt;
  int x_step;
  int m_a, m_b, m_d, m_op;

  int cur_t;
  int done_cnt    = 0;
  int done_t_last = -1;
  int req_cnt     = 0;

  // Per-instruction timeline, index = cycles after the accepting edge
  bit e_pl [TMAX];
  bit e_ml [TMAX];
  bit e_ul [TMAX];
  bit e_req[TMAX];
  bit e_ack[TMAX];
  bit e_dn [TMAX];
  int e_step[TMAX];
  int t_end;
  int wq[256];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("instr_ready", int'(bus.instr_ready), int'(x_ready));
      chk("busy",        int'(bus.busy),        int'(x_busy));
      chk("pim_load",    int'(bus.pim_load),    int'(x_pl));
      chk("mov_load",    int'(bus.mov_load),    int'(x_ml));
      chk("update_load", int'(bus.update_load), int'(x_ul));
      chk("arr_req",     int'(bus.arr_req),     int'(x_req));
      chk("done",        int'(bus.done),        int'(x_done));
      chk("aborted",     int'(bus.aborted),     int'(x_abt));
      chk("step_cnt",    int'(bus.step_cnt),    x_step);
      chk("arr_op",      int'(bus.arr_op),      m_op);
      chk("src_a_d",     int'(bus.src_a_d),     m_a);
      chk("src_b_d",     int'(bus.src_b_d),     m_b);
      chk("dst_d",       int'(bus.dst_d),       m_d);
      chk("mov_d",       int'(bus.mov_d),       m_a);
      if (bus.done) begin
        done_cnt++;
        done_t_last = cur_t;
      end
      if (bus.arr_req) req_cnt++;
    end
  end

  task automatic set_idle(input bit abt);
    x_ready = 1'b1; x_busy = 1'b0; x_pl = 1'b0; x_ml = 1'b0;
    x_ul = 1'b0; x_req = 1'b0; x_done = 1'b0; x_abt = abt;
  endtask

  task automatic set_reset_model();
    set_idle(1'b0);
    x_step = 0; m_a = 0; m_b = 0; m_d = 0; m_op = 0;
  endtask

  // Lay out the cycle-by-cycle schedule from the step count and per-step ack waits
  task automatic build(input bit mov, input int len);
    int t;
    for (int i = 0; i < TMAX; i++) begin
      e_pl[i] = 0; e_ml[i] = 0; e_ul[i] = 0; e_req[i] = 0;
      e_ack[i] = 0; e_dn[i] = 0; e_step[i] = 0;
    end
    e_pl[1] = !mov;
    e_ml[1] = mov;
    t = 2;
    if (!mov) begin
      for (int i = 0; i < len; i++) begin
        for (int w = 0; w <= wq[i]; w++) begin
          e_req[t] = 1; e_step[t] = i; t++;
        end
        e_ack[t-1] = 1;
        if (i < len - 1) begin
          e_ul[t] = 1; e_step[t] = i + 1; t++;
        end
      end
    end
    e_dn[t]   = 1;
    e_step[t] = mov ? 0 : len;
    t_end     = t;
  endtask

  task automatic idle(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      cur_t = -1;
      bus.instr_valid = 1'b0;
      bus.abort       = noise && ($urandom % 2 == 1);
      bus.arr_ack     = noise && ($urandom % 2 == 1);
      set_idle(1'b0);
      @(posedge clk); #1;
    end
  endtask

  // ab_sel: 0 none, >0 abort in that cycle, <0 random
  task automatic run_txn(input bit mov, input int op, input int a, input int b,
                         input int d, input int len, input int ab_sel,
                         input bit noise, input int rst_at);
    int ab;
    logic [31:0] v;
    build(mov, len);
    ab = 0;
    if (ab_sel > 0) ab = ab_sel;
    else if (ab_sel < 0 && ($urandom % 4 == 0)) ab = $urandom_range(t_end, 1);
    if (ab > 0) begin
      t_end     = ab;
      e_ack[ab] = 0;
    end
    cur_t = 0;
    v = op;  bus.instr_op    = v[OW-1:0];
    v = a;   bus.instr_src_a = v[N-1:0];
    v = b;   bus.instr_src_b = v[N-1:0];
    v = d;   bus.instr_dst   = v[N-1:0];
    v = len; bus.instr_len   = v[LW-1:0];
    bus.instr_mov   = mov;
    bus.instr_valid = 1'b1;
    bus.abort       = noise && ($urandom % 2 == 1);
    bus.arr_ack     = noise && ($urandom % 2 == 1);
    set_idle(1'b0);
    @(posedge clk); #1;
    m_a = a; m_b = b; m_d = d; m_op = op;
    for (int t = 1; t <= t_end; t++) begin
      cur_t = t;
      bus.instr_valid = noise && ($urandom % 2 == 1);
      bus.instr_mov   = ($urandom % 2 == 1);
      bus.instr_op    = OW'($urandom);
      bus.instr_src_a = N'($urandom);
      bus.instr_len   = LW'($urandom);
      bus.abort       = (t == ab);
      bus.arr_ack     = e_ack[t] || (noise && !e_req[t] && ($urandom % 2 == 1));
      x_ready = 1'b0; x_busy = 1'b1; x_abt = 1'b0;
      x_pl = e_pl[t]; x_ml = e_ml[t]; x_ul = e_ul[t];
      x_req = e_req[t]; x_done = e_dn[t]; x_step = e_step[t];
      if (t == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        set_reset_model();
        chk("async_rst_arr_req", int'(bus.arr_req),     0);
        chk("async_rst_busy",    int'(bus.busy),        0);
        chk("async_rst_upd",     int'(bus.update_load), 0);
        chk("async_rst_ready",   int'(bus.instr_ready), 1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        bus.instr_valid = 1'b0; bus.abort = 1'b0; bus.arr_ack = 1'b0;
        cur_t = -1;
        return;
      end
      @(posedge clk); #1;
    end
    cur_t = t_end + 1;
    bus.instr_valid = 1'b0;
    bus.abort       = 1'b0;
    bus.arr_ack     = 1'b0;
    set_idle(ab > 0);
    x_step = e_step[t_end];
    @(posedge clk); #1;
  endtask

  int dc0, rc0, dt;

  task automatic snap();
    dc0 = done_cnt;
    rc0 = req_cnt;
  endtask

  function automatic int done_at();
    return (done_cnt > dc0) ? done_t_last : -1;
  endfunction

  initial begin
    bus.instr_valid = 1'b0; bus.instr_mov = 1'b0; bus.instr_op = '0;
    bus.instr_src_a = '0; bus.instr_src_b = '0; bus.instr_dst = '0;
    bus.instr_len = '0; bus.abort = 1'b0; bus.arr_ack = 1'b0;
    for (int i = 0; i < 256; i++) wq[i] = 0;
    cur_t = -1;
    set_reset_model();
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2, 1'b0);

    // PIM len=3 zero-wait
    snap();
    run_txn(1'b0, 3, 'h010, 'h020, 'h030, 3, 0, 1'b0, 0);
    chk("pin_len3_done_t", done_at(), 7);
    chk("pin_len3_reqs", req_cnt - rc0, 3);
    chk("pin_len3_step", int'(bus.step_cnt), 3);
    idle(1, 1'b0);

    // MOV
    snap();
    run_txn(1'b1, 5, 'h155, 'h0aa, 'h0f0, 4, 0, 1'b0, 0);
    chk("pin_mov_done_t", done_at(), 2);
    chk("pin_mov_reqs", req_cnt - rc0, 0);
    chk("pin_mov_d", int'(bus.mov_d), 'h155);

    // PIM len=0
    snap();
    run_txn(1'b0, 7, 'h3ff, 'h001, 'h002, 0, 0, 1'b0, 0);
    chk("pin_len0_done_t", done_at(), 2);
    chk("pin_len0_reqs", req_cnt - rc0, 0);

    // PIM len=2, three wait cycles per step
    wq[0] = 3; wq[1] = 3;
    snap();
    run_txn(1'b0, 9, 'h100, 'h200, 'h300, 2, 0, 1'b0, 0);
    chk("pin_wait_reqs", req_cnt - rc0, 8);
    chk("pin_wait_done_t", done_at(), 11);
    wq[0] = 0; wq[1] = 0;

    // Abort in the second ISSUE of len=4, then a normal instruction
    snap();
    run_txn(1'b0, 2, 'h011, 'h022, 'h033, 4, 4, 1'b0, 0);
    chk("pin_abort_no_done", done_cnt - dc0, 0);
    chk("pin_abort_reqs", req_cnt - rc0, 2);
    snap();
    run_txn(1'b0, 6, 'h044, 'h055, 'h066, 1, 0, 1'b0, 0);
    chk("pin_after_abort_done_t", done_at(), 3);

    // Reset during the first UPDATE of len=3, then len=1
    run_txn(1'b0, 3, 'h0de, 'h0ad, 'h0be, 3, 0, 1'b0, 3);
    idle(1, 1'b0);
    snap();
    run_txn(1'b0, 1, 'h077, 'h088, 'h099, 1, 0, 1'b0, 0);
    chk("pin_post_rst_done_t", done_at(), 3);

    // Full-range step count
    snap();
    run_txn(1'b0, 15, 'h3fe, 'h3fd, 'h3fc, 255, 0, 1'b0, 0);
    chk("pin_len255_step", int'(bus.step_cnt), 255);
    chk("pin_len255_reqs", req_cnt - rc0, 255);

    // Randomized instructions with ack/abort/valid noise
    for (int n = 0; n < 60; n++) begin
      int len;
      len = $urandom_range(6, 0);
      for (int i = 0; i < 8; i++) wq[i] = $urandom_range(3, 0);
      run_txn(($urandom % 4) == 0, $urandom_range(15, 0), $urandom_range(1023, 0),
              $urandom_range(1023, 0), $urandom_range(1023, 0), len, -1, 1'b1, 0);
      idle($urandom_range(2, 0), 1'b1);
    end

    dt = n_fail;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, dt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_pim_seq_ctrl
`default_nettype wire
